// File: rtl/ql_al4s3b_cell_macro_pkg.sv
// Shared constants and helpers for the fabric clock/reset dividers.
package ql_clk_pkg;

  localparam int DIV_W   = 8;
  localparam int DIV_MIN = 2;
  localparam int DIV_MAX = 256;

  // Length of the high phase: odd divisors get the extra reference cycle.
  function automatic int hi_len(input int div);
    return (div + 1) / 2;
  endfunction

endpackage

// File: rtl/ql_al4s3b_cell_macro_if.sv
// Clock/reset service bundle handed from the cell macro to fabric user logic.
interface ql_al4s3b_cell_macro_if;
  logic Sys_Clk0;
  logic Sys_Clk0_Rst;
  logic Sys_Clk1;
  logic Sys_Clk1_Rst;
  logic clk_ready;

  modport master (output Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst, clk_ready);
  modport slave  (input  Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst, clk_ready);
endinterface

// File: rtl/ql_al4s3b_cell_macro_clk_div.sv
// Integer clock divider with a stretched reset that releases on the falling
// edge of the RST_HOLD-th divided period.
module ql_clk_div
  import ql_clk_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int RST_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_o,
  output logic rst_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] HI   = DIV_W'(hi_len(DIV));
  localparam logic [DIV_W-1:0] HOLD = DIV_W'(RST_HOLD);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_rcnt;
  logic             r_clk;
  logic             r_rst;
  logic [DIV_W-1:0] w_nxt;
  logic             w_rise;
  logic             w_fall;

  assign w_nxt  = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  // Edges at which the registered clock goes 0->1 and 1->0 respectively.
  assign w_rise = (r_cnt == '0);
  assign w_fall = (r_cnt == HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rcnt <= '0;
      r_clk  <= 1'b0;
      r_rst  <= 1'b1;
    end else begin
      r_cnt <= w_nxt;
      // Decode the pre-increment count so the clock rises on edge 1 after release.
      r_clk <= (r_cnt < HI);
      if (w_rise && (r_rcnt != HOLD))
        r_rcnt <= r_rcnt + 1'b1;
      if (w_fall && (r_rcnt == HOLD))
        r_rst <= 1'b0;
    end
  end

  assign clk_o = r_clk;
  assign rst_o = r_rst;

endmodule

// File: rtl/ql_al4s3b_cell_macro.sv
// EOS S3 fabric cell macro clock/reset service: Sys_Clk0 always, Sys_Clk1
// only when SYS_CLK1_EN is defined (otherwise tied off).
module ql_al4s3b_cell_macro
  import ql_clk_pkg::*;
#(
  parameter int DIV0     = 4,
  parameter int DIV1     = 8,
  parameter int RST_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ql_al4s3b_cell_macro_if.master      bus
);

  if (DIV0 < DIV_MIN || DIV0 > DIV_MAX) begin : g_bad_div0
    $error("DIV0 out of range 2..256");
  end
  if (DIV1 < DIV_MIN || DIV1 > DIV_MAX) begin : g_bad_div1
    $error("DIV1 out of range 2..256");
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
    $error("RST_HOLD out of range 1..255");
  end

  logic w_clk0;
  logic w_rst0;

  ql_clk_div #(.DIV(DIV0), .RST_HOLD(RST_HOLD)) u_div0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_o (w_clk0),
    .rst_o (w_rst0)
  );

  assign bus.Sys_Clk0     = w_clk0;
  assign bus.Sys_Clk0_Rst = w_rst0;
  assign bus.clk_ready    = ~w_rst0;

`ifdef SYS_CLK1_EN
  logic w_clk1;
  logic w_rst1;

  ql_clk_div #(.DIV(DIV1), .RST_HOLD(RST_HOLD)) u_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_o (w_clk1),
    .rst_o (w_rst1)
  );

  assign bus.Sys_Clk1     = w_clk1;
  assign bus.Sys_Clk1_Rst = w_rst1;
`else
  assign bus.Sys_Clk1     = 1'b0;
  assign bus.Sys_Clk1_Rst = 1'b1;
`endif

endmodule

// File: tb/tb_ql_al4s3b_cell_macro.sv
// Directed bench: default divider (DIV0=4) and an odd divider (DIV0=5) side by side.
module tb_ql_al4s3b_cell_macro;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ql_al4s3b_cell_macro_if bus();
  ql_al4s3b_cell_macro_if bus5();

  ql_al4s3b_cell_macro u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ql_al4s3b_cell_macro #(.DIV0(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Divided clock is high for the first ceil(div/2) edges of each period.
  function automatic logic exp_clk(input int n, input int div);
    return ((n - 1) % div) < ((div + 1) / 2);
  endfunction

  task automatic chk_reset(input string tag);
    chk($sformatf("%s_clk0", tag),  32'(bus.Sys_Clk0),      32'd0);
    chk($sformatf("%s_rst0", tag),  32'(bus.Sys_Clk0_Rst),  32'd1);
    chk($sformatf("%s_rdy", tag),   32'(bus.clk_ready),     32'd0);
    chk($sformatf("%s_clk1", tag),  32'(bus.Sys_Clk1),      32'd0);
    chk($sformatf("%s_rst1", tag),  32'(bus.Sys_Clk1_Rst),  32'd1);
    chk($sformatf("%s_clk5", tag),  32'(bus5.Sys_Clk0),     32'd0);
    chk($sformatf("%s_rst5", tag),  32'(bus5.Sys_Clk0_Rst), 32'd1);
  endtask

  // Expected outputs at edge n after reset release.
  task automatic chk_run(input int n);
    chk($sformatf("clk0@%0d", n), 32'(bus.Sys_Clk0),      32'(exp_clk(n, 4)));
    chk($sformatf("rst0@%0d", n), 32'(bus.Sys_Clk0_Rst),  32'(n < 15));
    chk($sformatf("rdy@%0d", n),  32'(bus.clk_ready),     32'(n >= 15));
    chk($sformatf("clk5@%0d", n), 32'(bus5.Sys_Clk0),     32'(exp_clk(n, 5)));
    chk($sformatf("rst5@%0d", n), 32'(bus5.Sys_Clk0_Rst), 32'(n < 19));
`ifdef SYS_CLK1_EN
    chk($sformatf("clk1@%0d", n), 32'(bus.Sys_Clk1),      32'(exp_clk(n, 8)));
    chk($sformatf("rst1@%0d", n), 32'(bus.Sys_Clk1_Rst),  32'(n < 29));
`else
    chk($sformatf("clk1@%0d", n), 32'(bus.Sys_Clk1),      32'd0);
    chk($sformatf("rst1@%0d", n), 32'(bus.Sys_Clk1_Rst),  32'd1);
`endif
  endtask

  initial begin
    int   rises;
    logic prev;

    // Power-on reset held for 5 edges.
    rst_n = 1'b0;
    repeat (5) begin
      tick();
      chk_reset("por");
    end

    // Release: default, odd and reset-hold behaviour over 115 edges.
    rst_n = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int n = 1; n <= 115; n++) begin
      tick();
      chk_run(n);
      if (n <= 40 && bus.Sys_Clk0 && !prev) rises++;
      prev = bus.Sys_Clk0;
    end
    chk("rises_in_40", 32'(rises), 32'd10);

    // Fresh reset, then a mid-run reset between edges 22 and 23.
    rst_n = 1'b0;
    #1;
    chk_reset("rearm");
    repeat (2) begin
      tick();
      chk_reset("rearm_hold");
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick();
      chk_run(n);
    end
    rst_n = 1'b0;
    #1;
    chk_reset("mid_async");
    repeat (3) begin
      tick();
      chk_reset("mid_hold");
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      chk_run(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
